// File: rtl/mod_counter.sv
// Parametrised up/down modulo counter with programmable inclusive limit, wrap/saturate/one-shot
// overflow modes, a terminal-count pulse, a sticky overflow flag and a one-shot busy indication.
module mod_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             asyn_rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             en,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] counter,
  output logic             tc,
  output logic             ovf,
  output logic             busy
);

  localparam logic [1:0] ModeWrap    = 2'b00;
  localparam logic [1:0] ModeSat     = 2'b01;
  localparam logic [1:0] ModeOneShot = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  logic             one_shot;
  logic             at_bound;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] cnt_dec;

  assign one_shot = (mode == ModeOneShot);

  // >= catches max_val being lowered below the current count.
  assign at_bound = up_dn ? (cnt_q >= max_val) : (cnt_q == '0);
  assign load_val = (data_in > max_val) ? max_val : data_in;
  assign cnt_inc  = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
  assign cnt_dec  = cnt_q - {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    cnt_d   = cnt_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    state_d = one_shot ? state_q : StIdle;

    if (clr) begin
      cnt_d   = '0;
      ovf_d   = 1'b0;
      state_d = StIdle;
    end else if (load) begin
      cnt_d   = load_val;
      state_d = StIdle;
    end else if (en) begin
      if (one_shot && (state_q == StDone)) begin
        cnt_d = cnt_q;
      end else if (at_bound) begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;
        unique case (mode)
          ModeSat:     cnt_d = cnt_q;
          ModeOneShot: state_d = StDone;
          // ModeWrap and the reserved encoding both wrap.
          default:     cnt_d = up_dn ? '0 : max_val;
        endcase
      end else begin
        cnt_d = up_dn ? cnt_inc : cnt_dec;
        if (one_shot) begin
          state_d = StRun;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge asyn_rst_n) begin
    if (!asyn_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign counter = cnt_q;
  assign tc      = tc_q;
  assign ovf     = ovf_q;
  assign busy    = (state_q == StRun);

  logic unused_mode;
  assign unused_mode = (mode == ModeWrap);

endmodule

// File: tb/tb_mod_counter.sv
// Directed scoreboard bench for mod_counter: expectations are queued as stimulus is driven and
// popped/compared one time unit after the resulting clock edge.
module tb_mod_counter;

  logic       clk;
  logic       asyn_rst_n;
  logic       clr;
  logic       load;
  logic [7:0] data_in;
  logic       en;
  logic       up_dn;
  logic [1:0] mode;
  logic [7:0] max_val;
  logic [7:0] counter;
  logic       tc;
  logic       ovf;
  logic       busy;

  typedef struct {
    logic [7:0] cnt;
    logic       tc;
    logic       ovf;
    logic       busy;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mod_counter #(.WIDTH(8)) dut (
    .clk       (clk),
    .asyn_rst_n(asyn_rst_n),
    .clr       (clr),
    .load      (load),
    .data_in   (data_in),
    .en        (en),
    .up_dn     (up_dn),
    .mode      (mode),
    .max_val   (max_val),
    .counter   (counter),
    .tc        (tc),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_out(input logic [7:0] c, input logic t, input logic o, input logic b,
                            input string tag);
    exp_t e;
    e.cnt  = c;
    e.tc   = t;
    e.ovf  = o;
    e.busy = b;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard: observed empty queue, expected an entry");
    end else begin
      e = sb.pop_front();
      assert ({counter, tc, ovf, busy} === {e.cnt, e.tc, e.ovf, e.busy}) else begin
        errors++;
        $error("FAIL %s: observed cnt=%0d tc=%b ovf=%b busy=%b, expected cnt=%0d tc=%b ovf=%b busy=%b",
               e.tag, counter, tc, ovf, busy, e.cnt, e.tc, e.ovf, e.busy);
      end
    end
  endtask

  // Drive one cycle of inputs, queue the post-edge expectation, then sample after the edge.
  task automatic cyc(input logic c, input logic l, input logic [7:0] d, input logic e,
                     input logic u, input logic [1:0] m, input logic [7:0] mx,
                     input logic [7:0] ec, input logic etc, input logic eovf, input logic ebusy,
                     input string tag);
    clr     = c;
    load    = l;
    data_in = d;
    en      = e;
    up_dn   = u;
    mode    = m;
    max_val = mx;
    expect_out(ec, etc, eovf, ebusy, tag);
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    asyn_rst_n = 1'b0;
    clr = 1'b0; load = 1'b0; data_in = '0; en = 1'b0; up_dn = 1'b1; mode = 2'b00;
    max_val = 8'd9;
    #12;
    expect_out(8'd0, 1'b0, 1'b0, 1'b0, "reset");
    compare();
    asyn_rst_n = 1'b1;

    // Wrap up, limit 9.
    for (int i = 1; i <= 9; i++) begin
      cyc(0, 0, 0, 1, 1, 2'b00, 8'd9, 8'(i), 0, 0, 0, "wrap_up_count");
    end
    cyc(0, 0, 0, 1, 1, 2'b00, 8'd9, 8'd0, 1, 1, 0, "wrap_up_cross");
    cyc(0, 0, 0, 1, 1, 2'b00, 8'd9, 8'd1, 0, 1, 0, "wrap_up_after");

    // Saturate down.
    cyc(1, 0, 0, 0, 0, 2'b01, 8'd9, 8'd0, 0, 0, 0, "sat_clr0");
    cyc(0, 1, 8'd3, 0, 0, 2'b01, 8'd9, 8'd3, 0, 0, 0, "sat_load3");
    cyc(0, 0, 0, 1, 0, 2'b01, 8'd9, 8'd2, 0, 0, 0, "sat_dn2");
    cyc(0, 0, 0, 1, 0, 2'b01, 8'd9, 8'd1, 0, 0, 0, "sat_dn1");
    cyc(0, 0, 0, 1, 0, 2'b01, 8'd9, 8'd0, 0, 0, 0, "sat_dn0");
    cyc(0, 0, 0, 1, 0, 2'b01, 8'd9, 8'd0, 1, 1, 0, "sat_hold_a");
    cyc(0, 0, 0, 1, 0, 2'b01, 8'd9, 8'd0, 1, 1, 0, "sat_hold_b");
    cyc(1, 0, 0, 1, 0, 2'b01, 8'd9, 8'd0, 0, 0, 0, "sat_clr");

    // Load priority and clamp, limit 50.
    cyc(0, 1, 8'd200, 0, 1, 2'b00, 8'd50, 8'd50, 0, 0, 0, "load_clamp");
    cyc(0, 1, 8'd7, 1, 1, 2'b00, 8'd50, 8'd7, 0, 0, 0, "load_over_en");
    cyc(0, 0, 0, 0, 1, 2'b00, 8'd50, 8'd7, 0, 0, 0, "en0_hold");
    cyc(1, 1, 8'd9, 1, 1, 2'b00, 8'd50, 8'd0, 0, 0, 0, "clr_over_load");
    cyc(0, 0, 0, 1, 0, 2'b00, 8'd50, 8'd50, 1, 1, 0, "wrap_down");
    cyc(0, 0, 0, 1, 1, 2'b00, 8'd50, 8'd0, 1, 1, 0, "wrap_up_at_max");

    // One-shot up, limit 4.
    cyc(1, 0, 0, 0, 1, 2'b10, 8'd4, 8'd0, 0, 0, 0, "os_clr");
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 0, 0, 1, 1, 2'b10, 8'd4, 8'(i), 0, 0, 1, "os_run");
    end
    cyc(0, 0, 0, 1, 1, 2'b10, 8'd4, 8'd4, 1, 1, 0, "os_done");
    cyc(0, 0, 0, 1, 1, 2'b10, 8'd4, 8'd4, 0, 1, 0, "os_frozen");
    cyc(0, 1, 8'd0, 0, 1, 2'b10, 8'd4, 8'd0, 0, 1, 0, "os_load0");
    cyc(0, 0, 0, 1, 1, 2'b10, 8'd4, 8'd1, 0, 1, 1, "os_restart");

    // Leaving one-shot from DONE: reserved mode wraps.
    cyc(1, 0, 0, 0, 1, 2'b10, 8'd2, 8'd0, 0, 0, 0, "os2_clr");
    cyc(0, 0, 0, 1, 1, 2'b10, 8'd2, 8'd1, 0, 0, 1, "os2_run1");
    cyc(0, 0, 0, 1, 1, 2'b10, 8'd2, 8'd2, 0, 0, 1, "os2_run2");
    cyc(0, 0, 0, 1, 1, 2'b10, 8'd2, 8'd2, 1, 1, 0, "os2_done");
    cyc(0, 0, 0, 1, 1, 2'b11, 8'd2, 8'd0, 1, 1, 0, "mode11_wrap");

    // Async reset mid one-shot run at 7.
    cyc(1, 0, 0, 0, 1, 2'b10, 8'd10, 8'd0, 0, 0, 0, "ar_clr");
    for (int i = 1; i <= 7; i++) begin
      cyc(0, 0, 0, 1, 1, 2'b10, 8'd10, 8'(i), 0, 0, 1, "ar_run");
    end
    #2;
    asyn_rst_n = 1'b0;
    #1;
    expect_out(8'd0, 1'b0, 1'b0, 1'b0, "async_reset");
    compare();
    #1;
    asyn_rst_n = 1'b1;
    cyc(0, 0, 0, 1, 1, 2'b10, 8'd10, 8'd1, 0, 0, 1, "ar_first_step");

    // Limit edge cases.
    cyc(1, 0, 0, 0, 1, 2'b00, 8'd0, 8'd0, 0, 0, 0, "max0_clr");
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 1, 2'b00, 8'd0, 8'd0, 1, 1, 0, "max0_pinned");
    end
    cyc(1, 0, 0, 0, 1, 2'b00, 8'd100, 8'd0, 0, 0, 0, "lower_clr");
    cyc(0, 1, 8'd20, 0, 1, 2'b00, 8'd100, 8'd20, 0, 0, 0, "lower_load20");
    cyc(0, 0, 0, 1, 1, 2'b00, 8'd10, 8'd0, 1, 1, 0, "lower_wrap");
    cyc(0, 0, 0, 1, 1, 2'b00, 8'd10, 8'd1, 0, 1, 0, "lower_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
